wbmic_fifoctrl: RTL
===================

WBMIC_FIFOCTRL -- requirements
Module: wbmic_fifoctrl

Interface
REQ-001 SHALL have parameter BW, default 12, sample width in bits.
REQ-002 SHALL have parameter LGFLEN, default 9, log2 of the attached sample FIFO depth.
REQ-003 SHALL have parameter [13:0] DEF_THRESH, default 256, reset interrupt threshold.
REQ-004 SHALL have ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone request.
- i_wb_addr  in  2  register select.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  ack.
- o_wb_stall  out  1  stall.
- o_wb_data  out  32  read data.
- i_smpl_stb, i_smpl_data  in  1 / BW  new mic sample.
- o_fifo_rst, o_fifo_wr  out  1 each  FIFO reset and write.
- o_fifo_data  out  BW  FIFO write data.
- o_fifo_rd  out  1  FIFO pop.
- i_fifo_empty_n, i_fifo_err  in  1 each  FIFO not-empty, overflow.
- i_fifo_data  in  BW  FIFO head.
- i_fifo_status  in  16  {fill[13:0], half, empty_n}.
- o_int  out  1  interrupt.

Function
REQ-005 SHALL register map: 0 CTRL, 1 STATUS (RO), 2 DATA (RO, pop), 3 DROPS.
REQ-006 SHALL CTRL fields: bit0 EN, bit1 FRST (write-1 pulse, reads 0), bit2 IE, [29:16] THRESH; other bits read 0.
REQ-007 SHALL STATUS read value {i_fifo_err, 15'b0, i_fifo_status}.
REQ-008 SHALL DATA read value {valid, zeros, i_fifo_data zero-extended}; valid = i_fifo_empty_n && state==IDLE in the request cycle.
REQ-009 SHALL drive o_fifo_rd combinationally = i_wb_stb && !i_wb_we && addr==2 && i_fifo_empty_n && state==IDLE; exactly one pop per such request.
REQ-010 SHALL ack every i_wb_stb one cycle later, with o_wb_data valid in the ack cycle; o_wb_stall constant 0; i_wb_cyc low suppresses pending ack.
REQ-011 SHALL register o_fifo_wr/o_fifo_data one cycle after i_smpl_stb when EN=1 and state==IDLE; otherwise the sample is discarded.
REQ-012 SHALL FSM IDLE->FLUSH on CTRL write with FRST=1; FLUSH lasts 2 cycles with o_fifo_rst=1; then SETTLE 1 cycle with o_fifo_rst=0; then IDLE.
REQ-013 SHALL, in FLUSH/SETTLE, block writes and pops; a sample arriving in the FRST write cycle is lost.
REQ-014 SHALL re-issuing FRST during FLUSH/SETTLE restart FLUSH at cycle 1.
REQ-015 SHALL keep DROPS as a 16-bit counter incremented on i_smpl_stb while EN=1 and (i_fifo_err=1 or state!=IDLE), saturating at 0xFFFF.
REQ-016 SHALL clear DROPS on FRST or any write to address 3.
REQ-017 SHALL register o_int = IE && (i_fifo_err || (THRESH!=0 && fill>=THRESH)), fill = i_fifo_status[15:2], unsigned compare.
REQ-018 SHALL ignore writes to STATUS and DATA, and write-to-DATA shall not pop.

Reset
REQ-019 SHALL on i_rst: EN=0, IE=0, THRESH=DEF_THRESH, DROPS=0, state=FLUSH at cycle 1 (FIFO reset issued), o_wb_ack=0, o_fifo_wr=0, o_int=0, o_wb_data=0.
REQ-020 SHALL i_rst override any in-flight transaction; no ack for a request in the reset cycle.

Structure
REQ-021 SHALL place register addresses, CTRL bit positions, and FSM state encodings in shared package wbmic_pkg.
REQ-022 SHALL be a single flat module; the FIFO is external, no sub-modules.

Verification
REQ-023 SHALL cover: reset then 3 cycles idle -> o_fifo_rst high exactly cycles 1-2, CTRL reads 0x01000000.
REQ-024 SHALL cover: EN=1, samples 0x123, 0x456; two DATA reads -> 0x80000123 then 0x80000456, one o_fifo_rd each; third read -> 0x00000000, no o_fifo_rd.
REQ-025 SHALL cover: THRESH=4, IE=1, push 4 samples -> o_int rises the cycle after fill reaches 4; one pop -> o_int falls.
REQ-026 SHALL cover: i_fifo_err=1, EN=1, 5 samples -> DROPS reads 5; write addr 3 -> DROPS reads 0.
REQ-027 SHALL cover: FRST write coincident with i_smpl_stb -> no o_fifo_wr, DATA read during FLUSH returns valid=0 with ack at +1 cycle.

Source files
------------

// File: rtl/wbmic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbmic_pkg
// Purpose  : Register map, CTRL field positions and FSM states shared by the
//            mic sample FIFO controller.
// Revision : 1.0
// ============================================================================
package wbmic_pkg;

  localparam logic [1:0] c_addr_ctrl   = 2'd0;
  localparam logic [1:0] c_addr_status = 2'd1;
  localparam logic [1:0] c_addr_data   = 2'd2;
  localparam logic [1:0] c_addr_drops  = 2'd3;

  localparam int c_ctrl_en         = 0;
  localparam int c_ctrl_frst       = 1;
  localparam int c_ctrl_ie         = 2;
  localparam int c_ctrl_thresh_lsb = 16;
  localparam int c_ctrl_thresh_msb = 29;

  typedef enum logic [1:0] {
    c_st_idle   = 2'd0,
    c_st_flush  = 2'd1,
    c_st_settle = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wbmic_fifoctrl.sv
`default_nettype none
// ============================================================================
// Module   : wbmic_fifoctrl
// Purpose  : Wishbone front end for an external mic sample FIFO: push, pop,
//            flush sequencing, drop counting and fill-threshold interrupt.
// Revision : 1.0
// ============================================================================
module wbmic_fifoctrl
  import wbmic_pkg::*;
#(
  parameter int          BW         = 12,
  parameter int          LGFLEN     = 9,
  parameter logic [13:0] DEF_THRESH = 14'd256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [31:0]   o_wb_data,
  input  logic          i_smpl_stb,
  input  logic [BW-1:0] i_smpl_data,
  output logic          o_fifo_rst,
  output logic          o_fifo_wr,
  output logic [BW-1:0] o_fifo_data,
  output logic          o_fifo_rd,
  input  logic          i_fifo_empty_n,
  input  logic          i_fifo_err,
  input  logic [BW-1:0] i_fifo_data,
  input  logic [15:0]   i_fifo_status,
  output logic          o_int
);

  state_t        r_state, w_state_nx;
  logic          r_flush_cnt, w_flush_cnt_nx;
  logic          r_en, r_ie;
  logic [13:0]   r_thresh;
  logic [15:0]   r_drops;
  logic          r_ack, r_fifo_wr, r_int;
  logic [31:0]   r_rdata, w_rdata;
  logic [BW-1:0] r_fifo_data;
  logic          w_idle, w_wr_req, w_rd_req, w_ctrl_wr, w_frst, w_drops_clr, w_drop;
  logic [13:0]   w_fill;
  logic          w_unused;

  assign w_idle      = (r_state == c_st_idle);
  assign w_wr_req    = i_wb_stb && i_wb_we;
  assign w_rd_req    = i_wb_stb && !i_wb_we;
  assign w_ctrl_wr   = w_wr_req && (i_wb_addr == c_addr_ctrl);
  assign w_frst      = w_ctrl_wr && i_wb_data[c_ctrl_frst];
  assign w_drops_clr = w_frst || (w_wr_req && (i_wb_addr == c_addr_drops));
  assign w_drop      = i_smpl_stb && r_en && (i_fifo_err || !w_idle);
  assign w_fill      = i_fifo_status[15:2];
  // LGFLEN only describes the attached FIFO; fill arrives already sized
  assign w_unused    = ^{i_wb_data[31:30], i_wb_data[15:3], LGFLEN != 0};

  assign o_fifo_rd   = w_rd_req && (i_wb_addr == c_addr_data) && i_fifo_empty_n && w_idle;
  assign o_wb_ack    = r_ack;
  assign o_wb_stall  = 1'b0;
  assign o_wb_data   = r_rdata;
  assign o_fifo_wr   = r_fifo_wr;
  assign o_fifo_data = r_fifo_data;
  assign o_int       = r_int;

  always_comb begin
    w_rdata = '0;
    case (i_wb_addr)
      c_addr_ctrl: begin
        w_rdata[c_ctrl_en]                             = r_en;
        w_rdata[c_ctrl_ie]                             = r_ie;
        w_rdata[c_ctrl_thresh_msb:c_ctrl_thresh_lsb]   = r_thresh;
      end
      c_addr_status: w_rdata = {i_fifo_err, 15'b0, i_fifo_status};
      c_addr_data: begin
        w_rdata[31]     = i_fifo_empty_n && w_idle;
        w_rdata[BW-1:0] = i_fifo_data;
      end
      default: w_rdata[15:0] = r_drops;
    endcase
  end

  // A new FRST always restarts the flush from its first cycle
  always_comb begin
    w_state_nx     = r_state;
    w_flush_cnt_nx = r_flush_cnt;
    o_fifo_rst     = (r_state == c_st_flush);
    if (w_frst) begin
      w_state_nx     = c_st_flush;
      w_flush_cnt_nx = 1'b0;
    end else begin
      case (r_state)
        c_st_idle: ;
        c_st_flush: begin
          if (r_flush_cnt) w_state_nx = c_st_settle;
          else             w_flush_cnt_nx = 1'b1;
        end
        c_st_settle: w_state_nx = c_st_idle;
        default:     w_state_nx = c_st_idle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_st_flush;
      r_flush_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_flush_cnt <= w_flush_cnt_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_thresh  <= DEF_THRESH;
      r_drops   <= '0;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_fifo_wr <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      r_ack     <= i_wb_stb && i_wb_cyc;
      if (i_wb_stb) r_rdata <= w_rdata;
      r_fifo_wr <= i_smpl_stb && r_en && w_idle && !w_frst;
      if (w_ctrl_wr) begin
        r_en     <= i_wb_data[c_ctrl_en];
        r_ie     <= i_wb_data[c_ctrl_ie];
        r_thresh <= i_wb_data[c_ctrl_thresh_msb:c_ctrl_thresh_lsb];
      end
      if (w_drops_clr)                        r_drops <= '0;
      else if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
      r_int <= r_ie && (i_fifo_err || (r_thresh != 14'd0 && w_fill >= r_thresh));
    end
  end

  always_ff @(posedge i_clk) begin
    r_fifo_data <= i_smpl_data;
  end

endmodule
`default_nettype wire
